// File: rtl/fft_pkg.sv
// Shared FFT output-stage constants and helpers.
// Word width, serial order codes, counter width helper.
package fft_pkg;

  localparam int FFT_DW = 34;

  localparam logic ORDER_NATURAL   = 1'b0;
  localparam logic ORDER_TRANSPOSE = 1'b1;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/p_s_pingpong_if.sv
// Beat-in / word-out handshake bundle for the
// parallel-to-serial ping-pong converter.
interface p_s_pingpong_if #(
  parameter int DW    = 34,
  parameter int LANES = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic                  in_order;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic                  out_first;
  logic                  out_last;

  modport master (
    output in_valid,
    output in_data,
    output in_order,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_first,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_order,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_first,
    output out_last
  );

endinterface

// File: rtl/p_s_bank.sv
// One ping-pong bank: row write of a full beat,
// order-aware word read for the serial side.
module p_s_bank
  import fft_pkg::*;
#(
  parameter int  DW    = FFT_DW,
  parameter int  LANES = 4,
  parameter int  BEATS = 4,
  localparam int N     = LANES * BEATS,
  localparam int BW    = cw(BEATS),
  localparam int LW    = cw(LANES),
  localparam int IW    = cw(N)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [BW-1:0]       wr_row,
  input  logic [LANES*DW-1:0] wr_data,
  input  logic [IW-1:0]       rd_idx,
  input  logic                order,
  output logic [DW-1:0]       rd_word
);

  // One extra bit so the divisors never truncate.
  localparam int XW = IW + 1;

  logic [DW-1:0] mem [BEATS][LANES];

  logic [XW-1:0] k;
  logic [BW-1:0] beat;
  logic [LW-1:0] lane;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        mem[wr_row][l] <= wr_data[l*DW +: DW];
      end
    end
  end

  assign k = XW'(rd_idx);

  always_comb begin
    beat = '0;
    lane = '0;
    unique case (order)
      ORDER_NATURAL: begin
        beat = BW'(k / XW'(LANES));
        lane = LW'(k % XW'(LANES));
      end
      ORDER_TRANSPOSE: begin
        lane = LW'(k / XW'(BEATS));
        beat = BW'(k % XW'(BEATS));
      end
    endcase
  end

  assign rd_word = mem[beat][lane];

endmodule

// File: rtl/p_s_pingpong.sv
// Parallel-to-serial FFT output converter with two
// ping-pong banks and per-frame natural/transposed order.
module p_s_pingpong
  import fft_pkg::*;
#(
  parameter int DW    = FFT_DW,
  parameter int LANES = 4,
  parameter int BEATS = 4
) (
  input  logic            clk,
  input  logic            rst,
  p_s_pingpong_if.slave   bus
);

  localparam int N  = LANES * BEATS;
  localparam int BW = cw(BEATS);
  localparam int IW = cw(N);

  logic [1:0]    full;
  logic [1:0]    order_q;
  logic          wr_bank;
  logic          rd_bank;
  logic [BW-1:0] wr_beat;
  logic [IW-1:0] rd_idx;

  logic          in_acc;
  logic          out_acc;
  logic          wr_end;
  logic          rd_end;
  logic [DW-1:0] word [2];

  assign bus.in_ready = !full[wr_bank];
  assign in_acc       = bus.in_valid && bus.in_ready;
  assign out_acc      = bus.out_valid && bus.out_ready;
  assign wr_end       = (wr_beat == BW'(BEATS - 1));
  assign rd_end       = (rd_idx == IW'(N - 1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    p_s_bank #(
      .DW    (DW),
      .LANES (LANES),
      .BEATS (BEATS)
    ) u_bank (
      .clk     (clk),
      .we      (in_acc && (wr_bank == 1'(b))),
      .wr_row  (wr_beat),
      .wr_data (bus.in_data),
      .rd_idx  (rd_idx),
      .order   (order_q[b]),
      .rd_word (word[b])
    );
  end

  // Write and read sides always touch different banks
  // when both complete on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      order_q <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_beat <= '0;
      rd_idx  <= '0;
    end else begin
      if (in_acc) begin
        if (wr_beat == '0) begin
          order_q[wr_bank] <= bus.in_order;
        end
        if (wr_end) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_beat       <= '0;
        end else begin
          wr_beat <= wr_beat + 1'b1;
        end
      end
      if (out_acc) begin
        if (rd_end) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_idx        <= '0;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = word[rd_bank];
  assign bus.out_first = full[rd_bank] && (rd_idx == '0);
  assign bus.out_last  = full[rd_bank] && rd_end;

endmodule

// File: tb/tb_p_s_pingpong.sv
// Scoreboard bench for p_s_pingpong: frames queue their
// expected words, a forked monitor pops on each accept.
module tb_p_s_pingpong;
  import fft_pkg::*;

  localparam int DW    = FFT_DW;
  localparam int LANES = 4;
  localparam int BEATS = 4;
  localparam int N     = LANES * BEATS;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  p_s_pingpong_if #(.DW(DW), .LANES(LANES)) bus ();

  p_s_pingpong #(
    .DW    (DW),
    .LANES (LANES),
    .BEATS (BEATS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   acc_t[$];
  int   checks    = 0;
  int   fails     = 0;
  int   popped    = 0;
  int   cyc       = 0;
  int   t_f1_last = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] exp_val(input int base,
                                            input bit ord,
                                            input int k);
    int beat;
    int lane;
    if (ord) begin
      lane = k / BEATS;
      beat = k % BEATS;
    end else begin
      beat = k / LANES;
      lane = k % LANES;
    end
    return DW'(base + beat * LANES + lane);
  endfunction

  task automatic send_frame(input int base, input bit ord0,
                            input bit ordx, input int nb,
                            output int t0);
    logic [LANES*DW-1:0] d;
    exp_t e;
    int n;
    t0 = -1;
    for (int b = 0; b < nb; b++) begin
      for (int l = 0; l < LANES; l++) begin
        d[l*DW +: DW] = DW'(base + b * LANES + l);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_order = (b == 0) ? ord0 : ordx;
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        n++;
        if (n > 200) begin
          chk("in_ready_timeout", 64'd0, 64'd1);
          break;
        end
      end
      if (b == 0) t0 = cyc;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (nb == BEATS) begin
      for (int k = 0; k < N; k++) begin
        e.d = exp_val(base, ord0, k);
        e.f = (k == 0);
        e.l = (k == N - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic monitor();
    exp_t e;
    logic [DW+1:0] h;
    bit held;
    held = 1'b0;
    h = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_stable",
            64'({bus.out_data, bus.out_first, bus.out_last}),
            64'(h));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word actual=%0h required=none",
                   bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("out_word",
              64'({bus.out_data, bus.out_first, bus.out_last}),
              64'({e.d, e.f, e.l}));
        end
        popped++;
        acc_t.push_back(cyc);
        if (bus.out_data == DW'('h10F) && bus.out_last) begin
          t_f1_last = cyc;
        end
      end
      held = bus.out_valid && !bus.out_ready;
      h    = {bus.out_data, bus.out_first, bus.out_last};
    end
  endtask

  initial begin
    int t0;
    int t3;
    int p0;
    int n;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_order  = 1'b0;
    bus.out_ready = 1'b0;

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_first", 64'(bus.out_first), 64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    @(posedge clk);
    #1;

    // natural order, first-word latency
    bus.out_ready = 1'b1;
    send_frame(0, ORDER_NATURAL, ORDER_NATURAL, BEATS, t0);
    @(negedge clk);
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_first", 64'(bus.out_first), 64'd1);
    wait_drain();
    @(negedge clk);
    chk("empty_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // transposed order
    send_frame(0, ORDER_TRANSPOSE, ORDER_TRANSPOSE, BEATS, t0);
    wait_drain();

    // three back-to-back frames
    p0 = popped;
    send_frame('h100, ORDER_NATURAL, ORDER_NATURAL, BEATS, t0);
    send_frame('h200, ORDER_NATURAL, ORDER_NATURAL, BEATS, t0);
    send_frame('h300, ORDER_NATURAL, ORDER_NATURAL, BEATS, t3);
    wait_drain();
    chk("f3_after_f1_last", 64'(t3), 64'(t_f1_last + 1));
    chk("gap_free_words", 64'(popped - p0), 64'd48);
    if (acc_t.size() >= p0 + 48) begin
      chk("gap_free_span", 64'(acc_t[p0 + 47] - acc_t[p0]), 64'd47);
    end

    // out_ready toggling
    bus.out_ready = 1'b0;
    send_frame('h400, ORDER_NATURAL, ORDER_NATURAL, BEATS, t0);
    p0 = popped;
    for (int i = 0; i < 32; i++) begin
      bus.out_ready = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    chk("toggle_count", 64'(popped - p0), 64'd16);
    chk("toggle_left", 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk("toggle_empty", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // per-frame order, in_order flipped mid-frame
    send_frame('h500, ORDER_NATURAL, ORDER_TRANSPOSE, BEATS, t0);
    send_frame('h600, ORDER_TRANSPOSE, ORDER_NATURAL, BEATS, t0);
    wait_drain();
    @(posedge clk);
    #1;

    // reset after three beats of a frame
    send_frame('h700, ORDER_NATURAL, ORDER_NATURAL, 3, t0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_part_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_part_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // reset while index 7 is presented
    p0 = popped;
    send_frame('h800, ORDER_NATURAL, ORDER_NATURAL, BEATS, t0);
    n = 0;
    while (popped - p0 < 7 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pos", 64'(popped - p0), 64'd7);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_drain_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_drain_out_last",  64'(bus.out_last),  64'd0);
    @(posedge clk);
    #1;

    // fresh frame after reset
    send_frame(0, ORDER_NATURAL, ORDER_NATURAL, BEATS, t0);
    wait_drain();
    @(negedge clk);
    chk("end_empty", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/p_s_pingpong.md
Name: p_s_pingpong

Overview:
Parametrised parallel-to-serial converter for the FFT output stage. Accepts one frame of LANES*BEATS complex words (LANES words per beat) and emits them one word per cycle, in natural or transposed order selectable per frame. Two ping-pong banks let frame k+1 load while frame k drains. Both sides use valid/ready handshakes with backpressure and carry frame-boundary markers. It replaces the fixed 4x4, flag-driven converter between the last butterfly stage and the serial output port.

Parameters:
DW, 34, width of one complex word (real+imag packed)
LANES, 4, words per input beat
BEATS, 4, input beats per frame; frame size N = LANES*BEATS

Ports:
clk  in  1  clock; one clock; reset is synchronous and active-high
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  LANES*DW  lane l at [l*DW +: DW]
in_order  in  1  output order for the frame; sampled with the first beat of the frame
out_valid  out  1  serial word valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  DW  serial word
out_first  out  1  high with output index 0
out_last  out  1  high with output index N-1

Behaviour:
- Storage: 2 banks of N words. Per bank: full flag and latched order bit. Write pointer wr_bank and beat counter wr_beat (0..BEATS-1). Read pointer rd_bank and index rd_idx (0..N-1).
- in_ready = !full[wr_bank]. On accept: store in_data into wr_bank at row wr_beat. If wr_beat==0, latch in_order into order[wr_bank]. On wr_beat==BEATS-1: set full[wr_bank], toggle wr_bank, wr_beat<=0. Otherwise wr_beat++.
- out_valid = full[rd_bank]. out_data is a combinational mux from the rd_bank storage.
- Natural order (0): index k -> beat k/LANES, lane k%LANES.
- Transposed order (1): index k -> lane k/BEATS, beat k%BEATS.
- On out accept: if rd_idx==N-1, clear full[rd_bank], toggle rd_bank, rd_idx<=0. Otherwise rd_idx++. Without out_ready, out_data, out_first and out_last hold stable.
- Latency: last beat accepted at edge t -> out_valid=1 with index 0 after edge t (first cycle t+1).
- Throughput: with out_ready held high, output is continuous across frames if the next frame completes before the current one drains. In the default config (4-cycle load, 16-cycle drain) input stalls 12 of every 16 cycles in steady state.
- Both banks full: in_ready=0 until the drain of rd_bank completes. The freed bank makes in_ready=1 in the cycle after the last-word accept edge; no same-cycle bypass.
- Same-edge final write and final read on different banks are independent; the flags update without conflict.
- Empty: out_valid=0, out_first=0, out_last=0; out_data is don't-care.
- Reset (also mid-frame): full[*]=0, wr_bank=rd_bank=0, wr_beat=0, rd_idx=0, order[*]=0 → in_ready=1, out_valid=0, out_first=0, out_last=0. Storage contents are not reset. Partial frames are discarded.
- in_order is ignored on beats other than the first.
- Parameter legality: LANES>=1, BEATS>=1, N>=2. Counter widths are $clog2 of the range, minimum 1 bit.

Decomposition:
- Shared package fft_pkg: FFT_DW=34, order constants ORDER_NATURAL=1'b0 and ORDER_TRANSPOSE=1'b1, clog2 helper if not built in.
- Sub-module p_s_bank: one bank's storage, a row write port (beat index + LANES*DW data), and an order-aware read mux (rd_idx, order -> DW word). Instantiate it twice. The top module holds the flags, pointers and handshake.

Test Plan:
- Word value = beat*LANES+lane. One frame, order 0, out_ready=1 → out_data 0,1,...,15 starting the cycle after beat 3 is accepted. out_first on 0, out_last on 15.
- Same frame, order 1 → out_data 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
- Three back-to-back frames (offsets 0x100, 0x200, 0x300), in_valid held high, out_ready=1 → in_ready drops after frame 2 loads. Frame 3 is accepted only after frame 1's out_last. Output is gap-free 0x100..0x30F in natural order.
- out_ready toggled 1,0 every cycle → each word held stable while stalled. 16 words in 32 cycles, no loss or duplication.
- Frame A order 1 loading while frame B order 0 drains; in_order changed mid-frame → each frame uses the order sampled at its first beat.
- Assert rst after beat 2 of a frame and during a drain at index 7 → next cycle out_valid=0, in_ready=1. A fresh full frame then outputs 0..15 correctly.
